// File: rtl/pwm_dimmer.sv
// Multi-channel PWM lamp dimmer. All channels share one PWM counter. Each
// channel's brightness level changes only at a PWM period boundary.
module pwm_dimmer #(
    parameter int CHANNELS  = 6,
    parameter int CNT_W     = 4,
    parameter int PRESCALE  = 1,
    parameter int FADE_EN   = 1,
    parameter int FADE_STEP = 1
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [CHANNELS-1:0] in,
    input  logic                lights,
    input  logic [CNT_W-1:0]    dim_level,
    output logic [CHANNELS-1:0] out,
    output logic                period_start
);

    localparam int FULL = 1 << CNT_W;
    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int LW   = CNT_W + 1;
    // Extra headroom so level +/- step never wraps before clamping.
    localparam int AW   = CNT_W + 2;

    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
    localparam logic [AW-1:0]   STEP    = AW'(FADE_STEP);
    localparam logic [AW-1:0]   FULL_A  = AW'(FULL);

    logic [PS_W-1:0]  prescaler;
    logic [CNT_W-1:0] pwm_cnt;
    logic             tick;
    logic             wrap;
    logic [LW-1:0]    level     [CHANNELS];
    logic [LW-1:0]    level_nxt [CHANNELS];

    function automatic logic [LW-1:0] step_level(input logic [LW-1:0] cur_l,
                                                 input logic [AW-1:0] tgt);
        logic [AW-1:0] cur;
        logic [AW-1:0] nxt;
        cur = AW'(cur_l);
        nxt = tgt;
        if (FADE_EN != 0) begin
            if (cur < tgt) begin
                nxt = (cur + STEP < tgt) ? cur + STEP : tgt;
            end else if (cur > tgt) begin
                nxt = (cur > tgt + STEP) ? cur - STEP : tgt;
            end
        end
        return nxt[LW-1:0];
    endfunction

    always_comb begin
        tick = (prescaler == PS_LAST);
        wrap = tick && (pwm_cnt == '1);
    end

    // Inputs are consumed here, but the result is only latched on wrap.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            level_nxt[i] = step_level(level[i],
                                      in[i]  ? FULL_A :
                                      lights ? AW'(dim_level) : '0);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prescaler    <= '0;
            pwm_cnt      <= '0;
            period_start <= 1'b0;
        end else begin
            prescaler    <= tick ? '0 : prescaler + 1'b1;
            if (tick) begin
                pwm_cnt <= pwm_cnt + 1'b1;
            end
            period_start <= wrap;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                level[i] <= '0;
            end
        end else if (wrap) begin
            for (int i = 0; i < CHANNELS; i++) begin
                level[i] <= level_nxt[i];
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                out[i] <= ({1'b0, pwm_cnt} < level[i]);
            end
        end
    end

endmodule

// File: tb/tb_pwm_dimmer.sv
// Bench for pwm_dimmer: a fading instance and a jump instance share the same
// stimulus, and every PWM period of both is scored against a level model.
module tb_pwm_dimmer;

    localparam int CH   = 6;
    localparam int CW   = 4;
    localparam int PS   = 2;
    localparam int STEP = 3;
    localparam int FULL = 1 << CW;
    localparam int PER  = FULL * PS;
    localparam int LV   = CW + 1;
    localparam int EW   = 2 * CH * LV;

    logic          clock;
    logic          reset_n;
    logic [CH-1:0] req;
    logic          lights;
    logic [CW-1:0] dim_level;
    logic [CH-1:0] out_a, out_b;
    logic          period_start_a, period_start_b;

    int n_tests = 0;
    int n_fail  = 0;

    logic [EW-1:0] exp_q[$];

    pwm_dimmer #(.CHANNELS(CH), .CNT_W(CW), .PRESCALE(PS), .FADE_EN(1), .FADE_STEP(STEP)) dut_a (
        .clock(clock), .reset_n(reset_n), .in(req), .lights(lights),
        .dim_level(dim_level), .out(out_a), .period_start(period_start_a)
    );

    pwm_dimmer #(.CHANNELS(CH), .CNT_W(CW), .PRESCALE(PS), .FADE_EN(0), .FADE_STEP(STEP)) dut_b (
        .clock(clock), .reset_n(reset_n), .in(req), .lights(lights),
        .dim_level(dim_level), .out(out_b), .period_start(period_start_b)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Boundaries fall on every PER-th rising edge after reset release; the
    // model samples the inputs there and pushes the levels for the next period.
    int edges;
    int m_a[CH];
    int m_b[CH];

    initial begin
        logic [EW-1:0] ent;
        int tgt;
        edges = 0;
        forever begin
            @(posedge clock);
            if (!reset_n) begin
                edges = 0;
                for (int c = 0; c < CH; c++) begin
                    m_a[c] = 0;
                    m_b[c] = 0;
                end
                exp_q.delete();
            end else begin
                edges++;
                if (edges % PER == 0) begin
                    ent = '0;
                    for (int c = 0; c < CH; c++) begin
                        tgt = req[c] ? FULL : (lights ? int'(dim_level) : 0);
                        if (m_a[c] < tgt)      m_a[c] = (m_a[c] + STEP < tgt) ? m_a[c] + STEP : tgt;
                        else if (m_a[c] > tgt) m_a[c] = (m_a[c] - STEP > tgt) ? m_a[c] - STEP : tgt;
                        m_b[c] = tgt;
                        ent[c*LV +: LV]        = LV'(m_a[c]);
                        ent[(CH+c)*LV +: LV]   = LV'(m_b[c]);
                    end
                    exp_q.push_back(ent);
                end
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    int  gap_a, gap_b;
    bit  win;
    int  win_k;
    int  lvl_e[2][CH];
    int  hi[2][CH];
    int  mis[2][CH];

    initial begin
        logic [EW-1:0] ent;
        bit o;
        bit e;
        win = 0; win_k = 0; gap_a = 0; gap_b = 0;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                win = 0; gap_a = 0; gap_b = 0;
            end else begin
                gap_a++;
                gap_b++;
                if (win) begin
                    for (int d = 0; d < 2; d++) begin
                        for (int c = 0; c < CH; c++) begin
                            o = (d == 0) ? out_a[c] : out_b[c];
                            e = (win_k < lvl_e[d][c] * PS);
                            hi[d][c] += int'(o);
                            if (o != e) mis[d][c]++;
                        end
                    end
                    win_k++;
                    if (win_k == PER) begin
                        win = 0;
                        for (int d = 0; d < 2; d++) begin
                            for (int c = 0; c < CH; c++) begin
                                check($sformatf("dut%0d ch%0d high cycles", d, c), hi[d][c], lvl_e[d][c] * PS);
                                check($sformatf("dut%0d ch%0d waveform errors", d, c), mis[d][c], 0);
                            end
                        end
                    end
                end else begin
                    check("idle out_a", int'(out_a), 0);
                    check("idle out_b", int'(out_b), 0);
                end
                if (period_start_a || gap_a >= PER) begin
                    check("period_start_a spacing", period_start_a ? gap_a : -1, PER);
                    gap_a = 0;
                end
                if (period_start_b || gap_b >= PER) begin
                    check("period_start_b spacing", period_start_b ? gap_b : -1, PER);
                    gap_b = 0;
                end
                if (period_start_a) begin
                    if (exp_q.size() == 0) begin
                        check("expected entry available", 0, 1);
                    end else begin
                        ent = exp_q.pop_front();
                        for (int d = 0; d < 2; d++) begin
                            for (int c = 0; c < CH; c++) begin
                                lvl_e[d][c] = int'(ent[(d*CH+c)*LV +: LV]);
                                hi[d][c]    = 0;
                                mis[d][c]   = 0;
                            end
                        end
                        win   = 1;
                        win_k = 0;
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [CH-1:0] r, input logic l, input logic [CW-1:0] d);
        @(negedge clock);
        req       = r;
        lights    = l;
        dim_level = d;
    endtask

    task automatic hold_periods(input int n);
        repeat (n * PER) @(negedge clock);
    endtask

    task automatic release_reset();
        @(negedge clock);
        #2 reset_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    logic [CW-1:0] dim_tab [4];

    initial begin
        logic [CH-1:0] save;
        dim_tab[0] = '0; dim_tab[1] = 4'd1; dim_tab[2] = 4'd15; dim_tab[3] = 4'd8;
        reset_n = 1'b0; req = '0; lights = 1'b0; dim_level = '0;
        repeat (2) @(negedge clock);
        check("reset out_a", int'(out_a), 0);
        check("reset out_b", int'(out_b), 0);
        check("reset period_start", int'(period_start_a), 0);
        release_reset();

        // Ramp every lamp to full, then reset asynchronously mid-period.
        drive('1, 1'b0, '0);
        hold_periods(8);
        repeat (9) @(negedge clock);
        check("full-on out_a", int'(out_a), 6'h3F);
        check("full-on out_b", int'(out_b), 6'h3F);
        @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        check("async reset out_a", int'(out_a), 0);
        check("async reset out_b", int'(out_b), 0);
        check("async reset period_start", int'(period_start_a | period_start_b), 0);
        repeat (2) @(negedge clock);
        release_reset();

        // Dim glow, single channel on, then fade up and back down.
        drive('0, 1'b1, 4'd8);
        hold_periods(3);
        drive(6'b000001, 1'b0, 4'd8);
        hold_periods(3);
        drive(6'b000100, 1'b0, '0);
        hold_periods(7);
        drive('0, 1'b0, '0);
        hold_periods(7);

        // Random traffic with mid-period changes and short reverting glitches.
        repeat (60) begin
            repeat ($urandom_range(1, 40)) @(negedge clock);
            req       = CH'($urandom & $urandom);
            lights    = 1'($urandom);
            dim_level = ($urandom_range(0, 1) == 0) ? dim_tab[$urandom_range(0, 3)] : CW'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                save = req;
                @(negedge clock);
                req = ~save;
                repeat ($urandom_range(1, 3)) @(negedge clock);
                req = save;
            end
        end

        hold_periods(3);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
